l2_cache_read_pipe: RTL and testbench

//  Parametrised L2 data-read stage between directory and response stages. Issues one

---
 rtl/l2_cache_read_pipe.sv | 128 ++++++++++++
 tb/tb_l2_cache_read_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cache_read_pipe.sv
// L2 data-read stage: one SRAM line read per cycle plus sync-load reservation tracking.
// Latency 1; stall_pipeline freezes all outputs and the reservation table. Optional macro: L2_READ_BYPASS_EN.
module l2_cache_read_pipe #(
    parameter int NUM_WAYS      = 4,
    parameter int NUM_SETS      = 256,
    parameter int LINE_BITS     = 512,
    parameter int ADDR_WIDTH    = 26,
    parameter int TOTAL_STRANDS = 16,
    parameter int SIDEBAND_BITS = 600,
    localparam int WAY_W = $clog2(NUM_WAYS),
    localparam int SET_W = $clog2(NUM_SETS),
    localparam int IDX_W = WAY_W + SET_W,
    localparam int STR_W = $clog2(TOTAL_STRANDS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall_pipeline,
    input  logic                     dir_valid,
    input  logic [STR_W-1:0]         dir_strand,
    input  logic [2:0]               dir_op,
    input  logic [ADDR_WIDTH-1:0]    dir_address,
    input  logic                     dir_cache_hit,
    input  logic [WAY_W-1:0]         dir_hit_way,
    input  logic [WAY_W-1:0]         dir_fill_way,
    input  logic [NUM_WAYS-1:0]      dir_dirty,
    input  logic [SIDEBAND_BITS-1:0] dir_sideband,
    input  logic                     wr_enable,
    input  logic [IDX_W-1:0]         wr_index,
    input  logic [LINE_BITS-1:0]     wr_data,
    output logic                     rd_valid,
    output logic [STR_W-1:0]         rd_strand,
    output logic [2:0]               rd_op,
    output logic [ADDR_WIDTH-1:0]    rd_address,
    output logic                     rd_cache_hit,
    output logic [WAY_W-1:0]         rd_hit_way,
    output logic [WAY_W-1:0]         rd_fill_way,
    output logic                     rd_replace_is_dirty,
    output logic [SIDEBAND_BITS-1:0] rd_sideband,
    output logic [LINE_BITS-1:0]     rd_data,
    output logic                     rd_store_sync_success
);
    localparam logic [2:0] OP_STORE      = 3'd1;
    localparam logic [2:0] OP_LOAD_SYNC  = 3'd4;
    localparam logic [2:0] OP_STORE_SYNC = 3'd5;

    logic [LINE_BITS-1:0]  mem [NUM_WAYS*NUM_SETS];
    logic [TOTAL_STRANDS-1:0] res_valid;
    logic [ADDR_WIDTH-1:0] res_addr [TOTAL_STRANDS];

    logic [IDX_W-1:0]         read_idx;
    logic [LINE_BITS-1:0]     read_line;
    logic [TOTAL_STRANDS-1:0] addr_match;
    logic                     sync_success;
    logic                     accept;

    assign read_idx     = {(dir_cache_hit ? dir_hit_way : dir_fill_way), dir_address[SET_W-1:0]};
    assign accept       = dir_valid && !stall_pipeline && !reset;
    assign sync_success = addr_match[dir_strand];

    always_comb begin
        addr_match = '0;
        for (int i = 0; i < TOTAL_STRANDS; i++)
            addr_match[i] = res_valid[i] && (res_addr[i] == dir_address);
    end

    always_comb begin
        read_line = mem[read_idx];
`ifdef L2_READ_BYPASS_EN
        if (wr_enable && wr_index == read_idx)
            read_line = wr_data;
`endif
    end

    // Writes from the update stage must land even while this stage is stalled.
    always_ff @(posedge clk) begin
        if (wr_enable)
            mem[wr_index] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid              <= 1'b0;
            rd_strand             <= '0;
            rd_op                 <= '0;
            rd_address            <= '0;
            rd_cache_hit          <= 1'b0;
            rd_hit_way            <= '0;
            rd_fill_way           <= '0;
            rd_replace_is_dirty   <= 1'b0;
            rd_sideband           <= '0;
            rd_data               <= '0;
            rd_store_sync_success <= 1'b0;
        end else if (!stall_pipeline) begin
            rd_valid              <= dir_valid;
            rd_strand             <= dir_strand;
            rd_op                 <= dir_op;
            rd_address            <= dir_address;
            rd_cache_hit          <= dir_cache_hit;
            rd_hit_way            <= dir_hit_way;
            rd_fill_way           <= dir_fill_way;
            rd_replace_is_dirty   <= dir_dirty[dir_fill_way];
            rd_sideband           <= dir_sideband;
            rd_data               <= read_line;
            rd_store_sync_success <= dir_valid && (dir_op == OP_STORE_SYNC) && sync_success;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid <= '0;
            for (int i = 0; i < TOTAL_STRANDS; i++)
                res_addr[i] <= '0;
        end else if (accept) begin
            case (dir_op)
                OP_LOAD_SYNC: begin
                    res_valid[dir_strand] <= 1'b1;
                    res_addr[dir_strand]  <= dir_address;
                end
                OP_STORE:
                    res_valid <= res_valid & ~addr_match;
                OP_STORE_SYNC:
                    if (sync_success)
                        res_valid <= res_valid & ~addr_match;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_cache_read_pipe.sv
module tb_l2_cache_read_pipe;
    localparam int NW = 4, NS = 256, LB = 512, AW = 26, TS = 16, SB = 600;
    localparam int WW = 2, SW = 8, IW = 10, STW = 4;

    logic clk = 0;
    logic reset, stall_pipeline, dir_valid, dir_cache_hit, wr_enable;
    logic [STW-1:0] dir_strand;
    logic [2:0]     dir_op;
    logic [AW-1:0]  dir_address;
    logic [WW-1:0]  dir_hit_way, dir_fill_way;
    logic [NW-1:0]  dir_dirty;
    logic [SB-1:0]  dir_sideband;
    logic [IW-1:0]  wr_index;
    logic [LB-1:0]  wr_data;
    logic rd_valid, rd_cache_hit, rd_replace_is_dirty, rd_store_sync_success;
    logic [STW-1:0] rd_strand;
    logic [2:0]     rd_op;
    logic [AW-1:0]  rd_address;
    logic [WW-1:0]  rd_hit_way, rd_fill_way;
    logic [SB-1:0]  rd_sideband;
    logic [LB-1:0]  rd_data;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [LB-1:0] m_mem [NW*NS];
    int            res [int];
    logic e_valid, e_hit, e_dirty, e_ss;
    logic [STW-1:0] e_strand;
    logic [2:0]     e_op;
    logic [AW-1:0]  e_addr;
    logic [WW-1:0]  e_hw, e_fw;
    logic [SB-1:0]  e_sb;
    logic [LB-1:0]  e_data;

    l2_cache_read_pipe dut (
        .clk(clk), .reset(reset), .stall_pipeline(stall_pipeline),
        .dir_valid(dir_valid), .dir_strand(dir_strand), .dir_op(dir_op),
        .dir_address(dir_address), .dir_cache_hit(dir_cache_hit),
        .dir_hit_way(dir_hit_way), .dir_fill_way(dir_fill_way),
        .dir_dirty(dir_dirty), .dir_sideband(dir_sideband),
        .wr_enable(wr_enable), .wr_index(wr_index), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_strand(rd_strand), .rd_op(rd_op),
        .rd_address(rd_address), .rd_cache_hit(rd_cache_hit),
        .rd_hit_way(rd_hit_way), .rd_fill_way(rd_fill_way),
        .rd_replace_is_dirty(rd_replace_is_dirty), .rd_sideband(rd_sideband),
        .rd_data(rd_data), .rd_store_sync_success(rd_store_sync_success)
    );

    always #5 clk = ~clk;

    function automatic logic [LB-1:0] rand_line();
        logic [LB-1:0] r = '0;
        for (int i = 0; i < LB / 32; i++) r = (r << 32) | LB'($urandom);
        return r;
    endfunction

    function automatic logic [SB-1:0] rand_sb();
        logic [SB-1:0] r = '0;
        for (int i = 0; i < 19; i++) r = (r << 32) | SB'($urandom);
        return r;
    endfunction

    function automatic bit bypass_on();
`ifdef L2_READ_BYPASS_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Clear every reservation that holds address a.
    function automatic void clear_addr(int a);
        int q[$];
        foreach (res[k]) if (res[k] == a) q.push_back(k);
        foreach (q[j]) res.delete(q[j]);
    endfunction

    // Advance one clock, updating the model from the inputs present at the edge.
    task automatic cycle();
        int idx, a, s;
        if (reset) begin
            {e_valid, e_hit, e_dirty, e_ss, e_strand, e_op, e_addr, e_hw, e_fw} = '0;
            e_sb = '0; e_data = '0;
            res.delete();
        end else if (!stall_pipeline) begin
            idx = (dir_cache_hit ? int'(dir_hit_way) : int'(dir_fill_way)) * NS + int'(dir_address % NS);
            e_valid = dir_valid; e_strand = dir_strand; e_op = dir_op; e_addr = dir_address;
            e_hit = dir_cache_hit; e_hw = dir_hit_way; e_fw = dir_fill_way;
            e_dirty = dir_dirty[dir_fill_way]; e_sb = dir_sideband;
            e_data = (bypass_on() && wr_enable && int'(wr_index) == idx) ? wr_data : m_mem[idx];
            e_ss = 1'b0;
            a = int'(dir_address); s = int'(dir_strand);
            if (dir_valid) begin
                case (dir_op)
                    3'd4: res[s] = a;
                    3'd1: clear_addr(a);
                    3'd5: if (res.exists(s) && res[s] == a) begin e_ss = 1'b1; clear_addr(a); end
                    default: ;
                endcase
            end
        end
        if (wr_enable) m_mem[wr_index] = wr_data;
        @(posedge clk); #1;
    endtask

    task automatic set_req(input logic v, input int strand, input int op, input int addr,
                           input logic hit, input int hw, input int fw, input logic [3:0] dirty);
        dir_valid = v; dir_strand = STW'(strand); dir_op = 3'(op); dir_address = AW'(addr);
        dir_cache_hit = hit; dir_hit_way = WW'(hw); dir_fill_way = WW'(fw);
        dir_dirty = dirty; dir_sideband = rand_sb();
    endtask

    task automatic test_reset();
        reset = 1; stall_pipeline = 0; wr_enable = 0; wr_index = '0; wr_data = '0;
        set_req(1, 9, 5, 'h1234, 1, 1, 2, 4'hF);
        cycle(); cycle();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rd_valid); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", rd_data); end
        checks++; if ({rd_strand, rd_op, rd_address, rd_cache_hit, rd_replace_is_dirty, rd_store_sync_success} !== '0)
            begin errors++; $display("FAIL reset_fields got %h exp 0", {rd_strand, rd_op, rd_address}); end
        checks++; if (rd_sideband !== '0) begin errors++; $display("FAIL reset_sideband got nonzero exp 0"); end
        reset = 0;
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic preload();
        wr_enable = 1;
        for (int i = 0; i < NW * NS; i++) begin
            wr_index = IW'(i); wr_data = rand_line();
            cycle();
        end
        wr_enable = 0;
    endtask

    task automatic test_hit_read();
        wr_enable = 1; wr_index = {2'd2, 8'd5}; wr_data = {16{32'hA5A5A5A5}};
        cycle();
        wr_enable = 0;
        set_req(1, 2, 0, 5, 1, 2, 0, 0);
        cycle();
        checks++; if (rd_data !== {16{32'hA5A5A5A5}}) begin errors++; $display("FAIL hit_data got %h exp a5..", rd_data); end
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL hit_valid got %b exp 1", rd_valid); end
        checks++; if (rd_address !== AW'(5) || rd_hit_way !== 2'd2) begin errors++; $display("FAIL hit_fields got %h/%0d exp 5/2", rd_address, rd_hit_way); end
    endtask

    task automatic test_dirty();
        set_req(1, 0, 0, 'h77, 0, 1, 3, 4'b1000);
        cycle();
        checks++; if (rd_replace_is_dirty !== 1'b1) begin errors++; $display("FAIL dirty_set got %b exp 1", rd_replace_is_dirty); end
        checks++; if (rd_data !== m_mem[3*NS + 'h77]) begin errors++; $display("FAIL fill_data got %h exp %h", rd_data, m_mem[3*NS + 'h77]); end
        set_req(1, 0, 0, 'h77, 0, 1, 3, 4'b0111);
        cycle();
        checks++; if (rd_replace_is_dirty !== 1'b0) begin errors++; $display("FAIL dirty_clr got %b exp 0", rd_replace_is_dirty); end
    endtask

    task automatic test_sync();
        set_req(1, 3, 4, 'h40, 1, 0, 0, 0); cycle();
        checks++; if (rd_store_sync_success !== 1'b0) begin errors++; $display("FAIL ldsync_ss got %b exp 0", rd_store_sync_success); end
        set_req(1, 3, 5, 'h40, 1, 0, 0, 0); cycle();
        checks++; if (rd_store_sync_success !== 1'b1) begin errors++; $display("FAIL stsync_ok got %b exp 1", rd_store_sync_success); end
        cycle();
        checks++; if (rd_store_sync_success !== 1'b0) begin errors++; $display("FAIL stsync_repeat got %b exp 0", rd_store_sync_success); end
    endtask

    task automatic test_store_clears();
        set_req(1, 1, 4, 'h80, 1, 0, 0, 0); cycle();
        set_req(1, 2, 4, 'h80, 1, 0, 0, 0); cycle();
        set_req(1, 5, 1, 'h80, 1, 0, 0, 0); cycle();
        set_req(1, 1, 5, 'h80, 1, 0, 0, 0); cycle();
        checks++; if (rd_store_sync_success !== 1'b0) begin errors++; $display("FAIL store_clear got %b exp 0", rd_store_sync_success); end
        set_req(1, 6, 4, 'h90, 1, 0, 0, 0); cycle();
        set_req(1, 6, 4, 'h91, 1, 0, 0, 0); cycle();
        set_req(1, 6, 5, 'h90, 1, 0, 0, 0); cycle();
        checks++; if (rd_store_sync_success !== 1'b0) begin errors++; $display("FAIL overwrite_old got %b exp 0", rd_store_sync_success); end
        set_req(1, 6, 5, 'h91, 1, 0, 0, 0); cycle();
        checks++; if (rd_store_sync_success !== 1'b1) begin errors++; $display("FAIL overwrite_new got %b exp 1", rd_store_sync_success); end
    endtask

    task automatic test_stall();
        set_req(1, 10, 0, 'h3C, 1, 1, 2, 4'b0100); cycle();
        stall_pipeline = 1;
        for (int i = 0; i < 3; i++) begin
            set_req(1, 7, 4, 'h123 + i, 0, 3, 1, 4'b0010);
            wr_enable = 1; wr_index = {2'd1, 8'h3C}; wr_data = rand_line();
            cycle();
            checks++; if (rd_strand !== 4'd10 || rd_op !== 3'd0 || rd_address !== AW'('h3C) || rd_valid !== 1'b1)
                begin errors++; $display("FAIL stall_hold got %0d/%0d/%h exp 10/0/3c", rd_strand, rd_op, rd_address); end
            checks++; if (rd_data !== e_data || rd_sideband !== e_sb || rd_replace_is_dirty !== 1'b1)
                begin errors++; $display("FAIL stall_data got %h exp %h", rd_data, e_data); end
        end
        wr_enable = 0; stall_pipeline = 0;
        set_req(1, 7, 5, 'h123, 1, 0, 0, 0); cycle();
        checks++; if (rd_store_sync_success !== 1'b0) begin errors++; $display("FAIL stall_nores got %b exp 0", rd_store_sync_success); end
        set_req(1, 0, 0, 'h3C, 1, 1, 0, 0); cycle();
        checks++; if (rd_data !== m_mem[NS + 'h3C]) begin errors++; $display("FAIL stall_write got %h exp %h", rd_data, m_mem[NS + 'h3C]); end
    endtask

    task automatic test_collision();
        logic [LB-1:0] old_line, new_line;
        old_line = rand_line(); new_line = {LB{1'b1}};
        wr_enable = 1; wr_index = {2'd1, 8'd9}; wr_data = old_line; set_req(0, 0, 0, 0, 0, 0, 0, 0); cycle();
        wr_data = new_line; set_req(1, 0, 0, 9, 1, 1, 0, 0); cycle();
        wr_enable = 0;
        checks++; if (rd_data !== (bypass_on() ? new_line : old_line))
            begin errors++; $display("FAIL collision got %h exp %h", rd_data, bypass_on() ? new_line : old_line); end
        cycle();
        checks++; if (rd_data !== new_line) begin errors++; $display("FAIL after_coll got %h exp ff..", rd_data); end
    endtask

    task automatic test_reset_mid_stall();
        set_req(1, 4, 4, 'h222, 1, 0, 0, 0); cycle();
        stall_pipeline = 1; reset = 1; cycle();
        checks++; if (rd_valid !== 1'b0 || rd_data !== '0 || rd_strand !== '0)
            begin errors++; $display("FAIL rst_stall got %b/%0d exp 0/0", rd_valid, rd_strand); end
        stall_pipeline = 0; reset = 0;
        set_req(1, 4, 5, 'h222, 1, 0, 0, 0); cycle();
        checks++; if (rd_store_sync_success !== 1'b0) begin errors++; $display("FAIL rst_table got %b exp 0", rd_store_sync_success); end
    endtask

    task automatic test_random();
        int pool[8], ops[8], idx;
        ops = '{0, 1, 4, 5, 4, 5, 2, 3};
        for (int i = 0; i < 8; i++) pool[i] = int'($urandom_range(0, 1 << 20)) * NS + int'($urandom_range(0, 3));
        for (int n = 0; n < 500; n++) begin
            stall_pipeline = ($urandom_range(0, 3) == 0);
            set_req($urandom_range(0, 3) != 0, $urandom_range(0, 15), ops[$urandom_range(0, 7)],
                    pool[$urandom_range(0, 7)], 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 4'($urandom));
            wr_enable = 1'($urandom); wr_index = IW'($urandom); wr_data = rand_line();
            idx = (dir_cache_hit ? int'(dir_hit_way) : int'(dir_fill_way)) * NS + int'(dir_address % NS);
            if (!bypass_on() && int'(wr_index) == idx) wr_index[0] = ~wr_index[0];
            cycle();
            checks++; if (rd_valid !== e_valid) begin errors++; $display("FAIL rnd_valid n=%0d got %b exp %b", n, rd_valid, e_valid); end
            if (e_valid) begin
                checks++; if ({rd_strand, rd_op, rd_address, rd_cache_hit, rd_hit_way, rd_fill_way, rd_replace_is_dirty}
                              !== {e_strand, e_op, e_addr, e_hit, e_hw, e_fw, e_dirty})
                    begin errors++; $display("FAIL rnd_fields n=%0d got %h exp %h", n,
                        {rd_strand, rd_op, rd_address, rd_cache_hit, rd_hit_way, rd_fill_way, rd_replace_is_dirty},
                        {e_strand, e_op, e_addr, e_hit, e_hw, e_fw, e_dirty}); end
                checks++; if (rd_data !== e_data) begin errors++; $display("FAIL rnd_data n=%0d got %h exp %h", n, rd_data, e_data); end
                checks++; if (rd_sideband !== e_sb) begin errors++; $display("FAIL rnd_sideband n=%0d mismatch of pass-through", n); end
                checks++; if (rd_store_sync_success !== e_ss) begin errors++; $display("FAIL rnd_ss n=%0d got %b exp %b", n, rd_store_sync_success, e_ss); end
            end
        end
        stall_pipeline = 0; wr_enable = 0;
    endtask

    initial begin
        for (int i = 0; i < NW * NS; i++) m_mem[i] = '0;
        test_reset();
        preload();
        test_hit_read();
        test_dirty();
        test_sync();
        test_store_clears();
        test_stall();
        test_collision();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
